// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: opcode encodings, opcode enum and FSM states.
// Used by the RTL and by the testbench.
package seq_alu_pkg;

  localparam logic [2:0] OPC_AND = 3'b000;
  localparam logic [2:0] OPC_OR  = 3'b001;
  localparam logic [2:0] OPC_ADD = 3'b010;
  localparam logic [2:0] OPC_MUL = 3'b011;
  localparam logic [2:0] OPC_RSV = 3'b100;
  localparam logic [2:0] OPC_SLL = 3'b101;
  localparam logic [2:0] OPC_SUB = 3'b110;
  localparam logic [2:0] OPC_SLT = 3'b111;

  typedef enum logic [2:0] {
    OP_AND = OPC_AND,
    OP_OR  = OPC_OR,
    OP_ADD = OPC_ADD,
    OP_MUL = OPC_MUL,
    OP_RSV = OPC_RSV,
    OP_SLL = OPC_SLL,
    OP_SUB = OPC_SUB,
    OP_SLT = OPC_SLT
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_alu_adder.sv
// Single ripple adder of seq_alu. Serves ADD, SUB (b inverted, cin=1), SLT and,
// when the multiplier is built, the shift-add accumulation.
module seq_alu_adder
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             over
);

  logic [WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH];
  // b here is already the effective operand (inverted for subtraction).
  assign over = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with an IDLE/BUSY/DONE FSM. Single-cycle ops go
// straight to DONE; SLL shifts one bit per BUSY cycle.
// Optional feature macro: SEQ_ALU_MUL_EN (opcode 011 = shift-add multiply).
//
// Handshake: a command transfers on a rising edge where in_valid && in_ready;
// a result transfers on a rising edge where out_valid && out_ready. in_ready is
// high only in IDLE, out_valid only in DONE, and DONE holds result and flags
// steady until the transfer. The FSM state is visible on dbg_state_o.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       oper,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             c_out,
  output logic             over,
  output logic             illegal,
  output logic [1:0]       dbg_state_o
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             over_q, over_d;
  logic             ill_q, ill_d;
`ifdef SEQ_ALU_MUL_EN
  logic             mul_q, mul_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
`endif

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout, add_over;

  seq_alu_adder #(.WIDTH(WIDTH)) u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .sum  (add_sum),
    .cout (add_cout),
    .over (add_over)
  );

  // Adder operand select: live inputs in IDLE, accumulator during multiply.
  always_comb begin
    add_a   = a;
    add_b   = b;
    add_cin = 1'b0;
    if (oper == OPC_SUB || oper == OPC_SLT) begin
      add_b   = ~b;
      add_cin = 1'b1;
    end
`ifdef SEQ_ALU_MUL_EN
    if (state_q == ST_BUSY) begin
      add_a   = work_q;
      add_b   = mplier_q[0] ? mcand_q : '0;
      add_cin = 1'b0;
    end
`endif
  end

  // Next-state and datapath: capture on accept, iterate in BUSY, hold in DONE.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    zero_d  = zero_q;
    cout_d  = cout_q;
    over_d  = over_q;
    ill_d   = ill_q;
`ifdef SEQ_ALU_MUL_EN
    mul_d    = mul_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          cout_d  = 1'b0;
          over_d  = 1'b0;
          ill_d   = 1'b0;
          state_d = ST_DONE;
`ifdef SEQ_ALU_MUL_EN
          mul_d = 1'b0;
`endif
          case (oper)
            OPC_AND: work_d = a & b;
            OPC_OR:  work_d = a | b;
            OPC_ADD, OPC_SUB: begin
              work_d = add_sum;
              cout_d = add_cout;
              over_d = add_over;
            end
            OPC_SLT: begin
              work_d    = '0;
              work_d[0] = add_sum[WIDTH-1] ^ add_over;
            end
            OPC_SLL: begin
              work_d = a;
              cnt_d  = CW'(b[SW-1:0]);
              if (b[SW-1:0] != '0) state_d = ST_BUSY;
            end
`ifdef SEQ_ALU_MUL_EN
            OPC_MUL: begin
              work_d   = '0;
              mcand_d  = a;
              mplier_d = b;
              mul_d    = 1'b1;
              cnt_d    = CW'(WIDTH);
              state_d  = ST_BUSY;
            end
`endif
            default: begin
              work_d = '0;
              ill_d  = 1'b1;
            end
          endcase
          zero_d = (work_d == '0);
        end
      end
      ST_BUSY: begin
`ifdef SEQ_ALU_MUL_EN
        if (mul_q) begin
          work_d   = add_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end else begin
          work_d = work_q << 1;
        end
`else
        work_d = work_q << 1;
`endif
        cnt_d  = cnt_q - CW'(1);
        zero_d = (work_d == '0);
        if (cnt_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      zero_q  <= 1'b0;
      cout_q  <= 1'b0;
      over_q  <= 1'b0;
      ill_q   <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      mul_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      zero_q  <= zero_d;
      cout_q  <= cout_d;
      over_q  <= over_d;
      ill_q   <= ill_d;
`ifdef SEQ_ALU_MUL_EN
      mul_q    <= mul_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign out_valid   = (state_q == ST_DONE);
  assign result      = work_q;
  assign zero        = zero_q;
  assign c_out       = cout_q;
  assign over        = over_q;
  assign illegal     = ill_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (WIDTH=32). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_seq_alu;
  import seq_alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic [2:0]  oper;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, c_out, over, illegal;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int lat;
  bit busy_ready;
  int seen;

  seq_alu #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .oper        (oper),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .c_out       (c_out),
    .over        (over),
    .illegal     (illegal),
    .dbg_state_o (dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one command from IDLE and wait (bounded) for out_valid.
  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                       output int l, output bit rdy_busy);
    @(negedge clk);
    in_valid = 1'b1; oper = op; a = av; b = bv;
    @(negedge clk);
    in_valid = 1'b0; a = $urandom; b = $urandom; oper = 3'($urandom_range(0, 7));
    l = 1; rdy_busy = 1'b0;
    while (!out_valid && l < 100) begin
      if (in_ready) rdy_busy = 1'b1;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic check_out(input string tag, input int exp_lat, input logic [31:0] res,
                           input logic z, input logic c, input logic o, input logic il);
    chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".result"}, 64'(result), 64'(res));
    chk({tag, ".zero"}, 64'(zero), 64'(z));
    chk({tag, ".c_out"}, 64'(c_out), 64'(c));
    chk({tag, ".over"}, 64'(over), 64'(o));
    chk({tag, ".illegal"}, 64'(illegal), 64'(il));
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, ".idle_ready"}, 64'(in_ready), 64'd1);
    chk({tag, ".idle_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; oper = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.result", 64'(result), 64'd0);
    chk("rst.flags", 64'({zero, c_out, over, illegal}), 64'd0);
    chk("rst.state", 64'(dbg_state), 64'(ST_IDLE));

    issue(OPC_ADD, 32'hFFFF_FFFF, 32'h0000_0001, lat, busy_ready);
    check_out("add_wrap", 1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    release_out("add_wrap");

    issue(OPC_ADD, 32'h7FFF_FFFF, 32'h0000_0001, lat, busy_ready);
    check_out("add_ovf", 1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    release_out("add_ovf");

    issue(OPC_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, lat, busy_ready);
    check_out("sub_ovf", 1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0);
    release_out("sub_ovf");

    issue(OPC_SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, lat, busy_ready);
    check_out("slt_ovf", 1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    release_out("slt_ovf");

    issue(OPC_SLT, 32'h0000_0001, 32'h0000_0002, lat, busy_ready);
    check_out("slt_lt", 1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    release_out("slt_lt");

    issue(OPC_SUB, 32'h0000_0005, 32'h0000_0003, lat, busy_ready);
    check_out("sub_pos", 1, 32'h2, 1'b0, 1'b1, 1'b0, 1'b0);
    release_out("sub_pos");

    issue(OPC_AND, 32'h0000_F0F0, 32'h0000_FF00, lat, busy_ready);
    check_out("and", 1, 32'h0000_F000, 1'b0, 1'b0, 1'b0, 1'b0);
    release_out("and");

    issue(OPC_OR, 32'h0000_F0F0, 32'h0000_FF00, lat, busy_ready);
    check_out("or", 1, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0, 1'b0);
    release_out("or");

    issue(OPC_SLL, 32'h0000_0003, 32'd5, lat, busy_ready);
    check_out("sll5", 6, 32'h0000_0060, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sll5.busy_ready", 64'(busy_ready), 64'd0);
    release_out("sll5");

    issue(OPC_SLL, 32'h0000_1234, 32'd32, lat, busy_ready);
    check_out("sll0", 1, 32'h0000_1234, 1'b0, 1'b0, 1'b0, 1'b0);
    release_out("sll0");

    issue(OPC_SLL, 32'h8000_0001, 32'd1, lat, busy_ready);
    check_out("sll1", 2, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 1'b0);
    release_out("sll1");

    issue(OPC_RSV, 32'h1234_5678, 32'h9ABC_DEF0, lat, busy_ready);
    check_out("rsv", 1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    release_out("rsv");

`ifdef SEQ_ALU_MUL_EN
    issue(OPC_MUL, 32'd7, 32'd6, lat, busy_ready);
    check_out("mul", 33, 32'd42, 1'b0, 1'b0, 1'b0, 1'b0);
    release_out("mul");
`else
    issue(OPC_MUL, 32'd7, 32'd6, lat, busy_ready);
    check_out("mul_rsv", 1, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    release_out("mul_rsv");
`endif

    // Hold in DONE with a competing command on the inputs.
    issue(OPC_ADD, 32'd5, 32'd3, lat, busy_ready);
    check_out("hold", 1, 32'd8, 1'b0, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      a = $urandom; b = $urandom; oper = OPC_AND;
      @(negedge clk);
      chk("hold.result", 64'(result), 64'd8);
      chk("hold.flags", 64'({zero, c_out, over, illegal}), 64'd0);
      chk("hold.valid", 64'(out_valid), 64'd1);
      chk("hold.in_ready", 64'(in_ready), 64'd0);
    end
    a = 32'd0; b = 32'd0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("hold.release_ready", 64'(in_ready), 64'd1);
    chk("hold.release_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("hold.no_accept", 64'(out_valid), 64'd0);
    chk("hold.still_idle", 64'(in_ready), 64'd1);

    // Reset during a long shift aborts it.
    @(negedge clk);
    in_valid = 1'b1; oper = OPC_SLL; a = 32'd1; b = 32'd31;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort.busy", 64'(dbg_state), 64'(ST_BUSY));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort.in_ready", 64'(in_ready), 64'd1);
    chk("abort.out_valid", 64'(out_valid), 64'd0);
    chk("abort.result", 64'(result), 64'd0);
    chk("abort.flags", 64'({zero, c_out, over, illegal}), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort.no_valid", 64'(seen), 64'd0);

    // Reset wins over a simultaneous command.
    rst = 1'b1; in_valid = 1'b1; oper = OPC_ADD; a = 32'd1; b = 32'd1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("rstpri.in_ready", 64'(in_ready), 64'd1);
    chk("rstpri.out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("rstpri.not_accepted", 64'(out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 One clock; reset is synchronous and active-high; ports clk and rst.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  operands and opcode present.
REQ-006 in_ready  output  1  block can accept a command.
REQ-007 a, b  input  WIDTH  operands.
REQ-008 oper  input  3  opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT, 101 SLL, 011 MUL (macro), 100 reserved.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  WIDTH  operation result.
REQ-012 zero, c_out, over, illegal  output  1 each  result==0, adder carry-out, signed overflow, and unsupported opcode, respectively.

Function
REQ-013 FSM states are IDLE, BUSY and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-014 A command is accepted on any clk edge with in_valid&&in_ready; a, b and oper are captured into internal registers at that edge.
REQ-015 AND, OR, ADD, SUB, SLT, reserved opcode, and SLL with shamt 0: IDLE->DONE; result valid 1 cycle after acceptance.
REQ-016 SUB computes a + ~b + 1 through the same adder as ADD; c_out is the adder carry-out of bit WIDTH-1.
REQ-017 over = (sign a == sign b') && (sign sum != sign a), where b' is b for ADD and ~b for SUB; over SHALL be 0 for all other ops.
REQ-018 c_out SHALL be 0 for ops other than ADD and SUB.
REQ-019 SLT result = {WIDTH-1 zeros, sum[WIDTH-1] ^ over} of a-b, giving a correct signed compare when overflow occurs.
REQ-020 SLL shamt = b[$clog2(WIDTH)-1:0]; for shamt>0: IDLE->BUSY, shift the working register left one bit per cycle with zero fill, then BUSY->DONE after exactly shamt shifts; latency = shamt+1 cycles.
REQ-021 Reserved opcode 100 SHALL give result 0, illegal 1, zero 1, and all other flags 0.
REQ-022 zero SHALL equal (result == 0) for every op and SHALL be registered with result.
REQ-023 result and all flags SHALL remain stable in DONE until out_valid&&out_ready, then DONE->IDLE; no new command is accepted in the same cycle.
REQ-024 Inputs a, b and oper are don't-care while not in IDLE; changing them SHALL NOT affect an in-flight operation.

Reset
REQ-025 rst SHALL force state IDLE, in_ready 1 on the next cycle, out_valid 0, and result, zero, c_out, over and illegal to 0.
REQ-026 rst asserted in BUSY or DONE SHALL abort the operation; no out_valid SHALL be produced for the aborted command.
REQ-027 rst has priority over a simultaneous in_valid; the command is not accepted.

Configuration
REQ-028 Macro SEQ_ALU_MUL_EN defined: opcode 011 performs unsigned shift-add multiply, taking WIDTH cycles in BUSY (latency WIDTH+1); result is the low WIDTH bits of the product; c_out = 0, over = 0.
REQ-029 SEQ_ALU_MUL_EN undefined: opcode 011 behaves as reserved per REQ-021, and no multiplier state is synthesised.

Structure
REQ-030 Package seq_alu_pkg SHALL hold the opcode enum (3-bit), the FSM state enum and the opcode localparams; it is shared with the bench.
REQ-031 Sub-module seq_alu_adder (parameter WIDTH; inputs a, b, cin; outputs sum, cout, over) SHALL be the only adder, used for ADD, SUB and SLT.

Verification (WIDTH=32)
REQ-032 ADD 0xFFFFFFFF+0x00000001 -> result 0, zero 1, c_out 1, over 0, out_valid 1 cycle after accept.
REQ-033 SUB 0x7FFFFFFF-0xFFFFFFFF -> result 0x80000000, over 1; SLT on same operands -> result 0 (signed +max > -1).
REQ-034 SLL a=0x00000003 b=5 -> result 0x60; out_valid exactly 6 cycles after accept; in_ready 0 throughout.
REQ-035 Hold out_ready 0 for 10 cycles in DONE -> result and flags stable, in_valid ignored; out_ready 1 -> IDLE next cycle.
REQ-036 rst pulse during BUSY of SLL b=31 -> no out_valid, in_ready 1 next cycle, all outputs 0.
REQ-037 oper=100 -> illegal 1, result 0; oper=011 with MUL_EN, a=7 b=6 -> result 42 after 33 cycles; without MUL_EN -> illegal 1.
